alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set operand/result width.
REQ-002 Parameter REG_COUNT, default 8, SHALL set register-file depth; IDX_W = clog2(REG_COUNT).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-007 in_oc  in  3  ALU opcode (000 add, 001 sub, 010 mul, 011 div, 100 not, 101 xor, 110 or, 111 and).
REQ-008 in_dst, in_src1, in_src2  in  IDX_W each  destination and source register indices.
REQ-009 in_imm_en  in  1; in_imm  in  DATA_WIDTH  when set, operand b SHALL be in_imm instead of reg[in_src2].
REQ-010 wr_en  in  1; wr_idx  in  IDX_W; wr_data  in  DATA_WIDTH  external register load port.
REQ-011 oc  out  3; a, b  out  DATA_WIDTH  drive the downstream combinational ALU.
REQ-012 f  in  DATA_WIDTH  ALU result, combinational function of oc/a/b.
REQ-013 res_valid  out  1; res_ready  in  1; res_data  out  DATA_WIDTH; res_dst  out  IDX_W; res_div0  out  1  completed-result stream.

Function
REQ-014 Two one-entry stages SHALL exist: issue (IS: valid, oc, a, b, dst) and result (RS: valid, data, dst, div0).
REQ-015 oc/a/b SHALL equal IS contents at all times (0 when IS invalid).
REQ-016 RS SHALL load from IS when IS valid and (RS invalid or res_ready); this is the "IS move".
REQ-017 in_ready SHALL equal !IS_valid || IS move; IS SHALL capture on acceptance, clear on move without acceptance.
REQ-018 Latency: request accepted at edge N SHALL appear on res_valid after edge N+1 when res_ready held high; throughput one per cycle.
REQ-019 On IS move, f SHALL be written to reg[IS.dst] and RS.data in the same edge.
REQ-020 Divide by zero: IS.oc==011 and IS.b==0 SHALL yield RS.data all-ones, res_div0=1, reg written with all-ones; otherwise res_div0=0.
REQ-021 Results SHALL be truncated to DATA_WIDTH (mul low half, sub modulo 2^DATA_WIDTH).
REQ-022 Forwarding: if IS valid and a source index equals IS.dst, that operand SHALL be taken from the div0-corrected f, not the register file.
REQ-023 External write SHALL update reg[wr_idx] at the edge; if same index as an IS-move writeback in that edge, writeback SHALL win.
REQ-024 External write SHALL NOT be forwarded: a same-cycle read of wr_idx returns the old value.
REQ-025 RS and res_* SHALL hold stable while res_valid && !res_ready.
REQ-026 Index >= REG_COUNT (non-power-of-two depth) SHALL read 0 and ignore writes.

Reset
REQ-027 rst SHALL clear IS_valid, RS_valid, all registers to 0, res_data/res_dst/res_div0/oc/a/b to 0; in_ready SHALL be 1 after reset.
REQ-028 rst asserted mid-operation SHALL discard in-flight IS/RS contents with no register writeback that edge; wr_en ignored while rst high.

Structure
REQ-029 Opcode constants (OC_ADD..OC_AND) and default DATA_WIDTH SHALL live in shared package alu_pkg, also used by alu.
REQ-030 Register file SHALL be sub-module reg_file (two async read ports, two prioritized sync write ports, sync reset).
REQ-031 The ALU SHALL remain external; alu_issue SHALL contain no arithmetic other than the b==0 compare.

Verification
REQ-032 Load r1=5, r2=3 via wr port; issue add r3=r1+r2, res_ready=1 -> res_valid two edges after accept, res_data=8, res_dst=3, r3=8.
REQ-033 Back-to-back: sub r4=r1-r2 then add r5=r4+r4 on next cycle -> second result 4 (forwarded), no stall.
REQ-034 div r6=r1/r0 with r0=0 -> res_data=0xFFFF, res_div0=1, r6=0xFFFF; next div r7=10/imm 3 -> 3, res_div0=0.
REQ-035 Hold res_ready=0 with three requests offered -> two accepted, in_ready=0, res_data stable; release -> results emerge in order.
REQ-036 wr_en to r3 same edge as writeback to r3 -> r3 holds ALU result; mul 0x0100*0x0100 -> 0x0000.
REQ-037 Assert rst with IS and RS valid -> next cycle res_valid=0, in_ready=1, all registers 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the issue stage and the downstream ALU:
//   opcode encoding, default datapath width and a small opcode helper.
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        OC_ADD = 3'b000,
        OC_SUB = 3'b001,
        OC_MUL = 3'b010,
        OC_DIV = 3'b011,
        OC_NOT = 3'b100,
        OC_XOR = 3'b101,
        OC_OR  = 3'b110,
        OC_AND = 3'b111
    } oc_e;

    // True when the opcode is a divide; the issue stage uses this to spot
    // divide-by-zero without knowing anything else about the ALU.
    function automatic logic oc_is_div(input logic [2:0] oc);
        return oc == OC_DIV;
    endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file
//   Register file with two asynchronous read ports and two synchronous
//   write ports. Write port A has priority over write port B when both
//   target the same entry. Indices >= REG_COUNT read as 0 and are not
//   written. Synchronous active-high reset clears every entry.
// Ports:
//   clk, rst                     clock, synchronous reset
//   rd0_idx/rd0_data             read port 0
//   rd1_idx/rd1_data             read port 1
//   wa_en/wa_idx/wa_data         write port A (high priority)
//   wb_en/wb_idx/wb_data         write port B (low priority)
module reg_file #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd0_idx,
    output logic [DATA_WIDTH-1:0] rd0_data,
    input  logic [IDX_W-1:0]      rd1_idx,
    output logic [DATA_WIDTH-1:0] rd1_data,
    input  logic                  wa_en,
    input  logic [IDX_W-1:0]      wa_idx,
    input  logic [DATA_WIDTH-1:0] wa_data,
    input  logic                  wb_en,
    input  logic [IDX_W-1:0]      wb_idx,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] mem_d [REG_COUNT];

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return int'(idx) < REG_COUNT;
    endfunction

    always_comb begin
        rd0_data = in_range(rd0_idx) ? mem_q[rd0_idx] : '0;
        rd1_data = in_range(rd1_idx) ? mem_q[rd1_idx] : '0;
    end

    // Port B is applied first so that port A overrides it on a collision.
    always_comb begin
        mem_d = mem_q;
        if (wb_en && in_range(wb_idx)) mem_d[wb_idx] = wb_data;
        if (wa_en && in_range(wa_idx)) mem_d[wa_idx] = wa_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Two-stage issue front end for an external combinational ALU.
//   IS (issue) holds the operation being evaluated; its contents drive
//   oc/a/b and the ALU answers on f. RS (result) holds the completed result
//   until the consumer takes it. A result is written back to the register
//   file when it moves from IS to RS, and is forwarded to a new request that
//   reads the register being produced.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               request handshake
//   in_oc, in_dst, in_src1, in_src2 opcode and register indices
//   in_imm_en, in_imm               immediate replaces source 2
//   wr_en, wr_idx, wr_data          external register load port
//   oc, a, b / f                    external ALU operands / result
//   res_valid/res_ready             result handshake
//   res_data, res_dst, res_div0     result payload
module alu_issue
    import alu_pkg::*;
#(
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  REG_COUNT  = 8,
    localparam int IDX_W      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_oc,
    input  logic [IDX_W-1:0]      in_dst,
    input  logic [IDX_W-1:0]      in_src1,
    input  logic [IDX_W-1:0]      in_src2,
    input  logic                  in_imm_en,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [2:0]            oc,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] f,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [IDX_W-1:0]      res_dst,
    output logic                  res_div0
);

    logic                  is_valid_q, is_valid_d;
    logic [2:0]            is_oc_q,    is_oc_d;
    logic [DATA_WIDTH-1:0] is_a_q,     is_a_d;
    logic [DATA_WIDTH-1:0] is_b_q,     is_b_d;
    logic [IDX_W-1:0]      is_dst_q,   is_dst_d;

    logic                  rs_valid_q, rs_valid_d;
    logic [DATA_WIDTH-1:0] rs_data_q,  rs_data_d;
    logic [IDX_W-1:0]      rs_dst_q,   rs_dst_d;
    logic                  rs_div0_q,  rs_div0_d;

    logic                  is_move;
    logic                  accept;
    logic                  div0;
    logic [DATA_WIDTH-1:0] f_wb;
    logic [DATA_WIDTH-1:0] rf_rd1, rf_rd2;
    logic [DATA_WIDTH-1:0] op_a, op_b;

    // The external write port is deliberately not forwarded: a request
    // reading wr_idx in the same cycle sees the value before the load.
    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .IDX_W      (IDX_W)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd0_idx  (in_src1),
        .rd0_data (rf_rd1),
        .rd1_idx  (in_src2),
        .rd1_data (rf_rd2),
        .wa_en    (is_move),
        .wa_idx   (is_dst_q),
        .wa_data  (f_wb),
        .wb_en    (wr_en),
        .wb_idx   (wr_idx),
        .wb_data  (wr_data)
    );

    always_comb begin
        is_move  = is_valid_q && (!rs_valid_q || res_ready);
        in_ready = !is_valid_q || is_move;
        accept   = in_valid && in_ready;

        // Divide by zero is decided here rather than trusting the ALU, so
        // the written-back and forwarded value is the corrected one.
        div0 = is_valid_q && oc_is_div(is_oc_q) && (is_b_q == '0);
        f_wb = div0 ? '1 : f;

        // The IS result is not in the register file yet; forward it.
        op_a = (is_valid_q && (in_src1 == is_dst_q)) ? f_wb : rf_rd1;
        if (in_imm_en)
            op_b = in_imm;
        else if (is_valid_q && (in_src2 == is_dst_q))
            op_b = f_wb;
        else
            op_b = rf_rd2;
    end

    always_comb begin
        is_valid_d = is_valid_q;
        is_oc_d    = is_oc_q;
        is_a_d     = is_a_q;
        is_b_d     = is_b_q;
        is_dst_d   = is_dst_q;
        if (accept) begin
            is_valid_d = 1'b1;
            is_oc_d    = in_oc;
            is_a_d     = op_a;
            is_b_d     = op_b;
            is_dst_d   = in_dst;
        end else if (is_move) begin
            // Emptied IS is zeroed so the ALU operand outputs read 0.
            is_valid_d = 1'b0;
            is_oc_d    = '0;
            is_a_d     = '0;
            is_b_d     = '0;
            is_dst_d   = '0;
        end
    end

    always_comb begin
        rs_valid_d = rs_valid_q;
        rs_data_d  = rs_data_q;
        rs_dst_d   = rs_dst_q;
        rs_div0_d  = rs_div0_q;
        if (is_move) begin
            rs_valid_d = 1'b1;
            rs_data_d  = f_wb;
            rs_dst_d   = is_dst_q;
            rs_div0_d  = div0;
        end else if (res_ready) begin
            rs_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_valid_q <= 1'b0;
            is_oc_q    <= '0;
            is_a_q     <= '0;
            is_b_q     <= '0;
            is_dst_q   <= '0;
            rs_valid_q <= 1'b0;
            rs_data_q  <= '0;
            rs_dst_q   <= '0;
            rs_div0_q  <= 1'b0;
        end else begin
            is_valid_q <= is_valid_d;
            is_oc_q    <= is_oc_d;
            is_a_q     <= is_a_d;
            is_b_q     <= is_b_d;
            is_dst_q   <= is_dst_d;
            rs_valid_q <= rs_valid_d;
            rs_data_q  <= rs_data_d;
            rs_dst_q   <= rs_dst_d;
            rs_div0_q  <= rs_div0_d;
        end
    end

    always_comb begin
        oc        = is_oc_q;
        a         = is_a_q;
        b         = is_b_q;
        res_valid = rs_valid_q;
        res_data  = rs_data_q;
        res_dst   = rs_dst_q;
        res_div0  = rs_div0_q;
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Directed scenarios followed by a randomized run checked against an
//   architectural model (register array + in-flight result queue).
module tb_alu_issue;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int RC = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [2:0]    in_oc;
    logic [IW-1:0] in_dst, in_src1, in_src2;
    logic          in_imm_en;
    logic [DW-1:0] in_imm;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic [2:0]    oc;
    logic [DW-1:0] a, b, f;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic [IW-1:0] res_dst;
    logic          res_div0;

    always #5 clk = ~clk;

    alu_issue #(.DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_oc(in_oc),
        .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .oc(oc), .a(a), .b(b), .f(f),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_dst(res_dst), .res_div0(res_div0)
    );

    // External ALU; on divide by zero it returns 0 so the DUT's
    // all-ones correction is visible.
    always_comb begin
        f = '0;
        case (oc)
            OC_ADD: f = a + b;
            OC_SUB: f = a - b;
            OC_MUL: f = a * b;
            OC_DIV: f = (b == '0) ? '0 : a / b;
            OC_NOT: f = ~a;
            OC_XOR: f = a ^ b;
            OC_OR:  f = a | b;
            OC_AND: f = a & b;
            default: f = '0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_oc = '0; in_dst = '0; in_src1 = '0; in_src2 = '0;
        in_imm_en = 1'b0; in_imm = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    endtask

    task automatic set_req(input logic [2:0] op, input int d, input int s1, input int s2,
                           input logic ie, input logic [DW-1:0] im);
        in_valid = 1'b1; in_oc = op; in_dst = IW'(d); in_src1 = IW'(s1);
        in_src2 = IW'(s2); in_imm_en = ie; in_imm = im;
    endtask

    task automatic load(input int idx, input logic [DW-1:0] val);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_data = val;
        tick();
        wr_en = 1'b0;
    endtask

    // Reads a register by issuing r = r | 0 and capturing the result.
    task automatic read_reg(input int idx, output logic [DW-1:0] val);
        res_ready = 1'b1;
        set_req(OC_OR, idx, idx, 0, 1'b1, '0);
        tick();
        in_valid = 1'b0;
        tick();
        val = res_data;
        tick();
    endtask

    // Architectural reference: results computed straight from the opcode
    // definitions, returned as {div0, result}.
    function automatic logic [DW:0] ref_op(input logic [2:0] op, input logic [DW-1:0] x,
                                           input logic [DW-1:0] y);
        int unsigned xa, yb, r;
        xa = x; yb = y; r = 0;
        case (op)
            3'd0: r = xa + yb;
            3'd1: r = xa - yb;
            3'd2: r = xa * yb;
            3'd3: begin
                if (yb == 0) return {1'b1, {DW{1'b1}}};
                r = xa / yb;
            end
            3'd4: r = ~xa;
            3'd5: r = xa ^ yb;
            3'd6: r = xa | yb;
            default: r = xa & yb;
        endcase
        return {1'b0, r[DW-1:0]};
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] dst;
        logic          div0;
        int            acc;
    } item_t;

    logic [DW-1:0] mregs [RC];
    item_t         q[$];
    item_t         it_new;
    logic [DW-1:0] v, opa, opb;
    logic [DW:0]   r;
    logic          exp_rdy, exp_vld, acc, pop;
    int            cyc;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        res_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_dst", res_dst, 0);
        chk("rst_res_div0", res_div0, 0);
        chk("rst_oc_a_b", {oc, a, b}, 0);

        // add r3 = r1 + r2 with two-edge latency
        load(1, 16'd5);
        load(2, 16'd3);
        set_req(OC_ADD, 3, 1, 2, 1'b0, '0);
        #1 chk("add_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("add_lat_not_yet", res_valid, 0);
        chk("add_is_oc", oc, OC_ADD);
        chk("add_is_a", a, 5);
        chk("add_is_b", b, 3);
        tick();
        chk("add_res_valid", res_valid, 1);
        chk("add_res_data", res_data, 8);
        chk("add_res_dst", res_dst, 3);
        chk("add_res_div0", res_div0, 0);
        tick();
        chk("add_drained", res_valid, 0);
        read_reg(3, v);
        chk("add_r3", v, 8);

        // back-to-back with forwarding
        set_req(OC_SUB, 4, 1, 2, 1'b0, '0);
        tick();
        set_req(OC_ADD, 5, 4, 4, 1'b0, '0);
        #1 chk("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_sub_data", res_data, 2);
        chk("b2b_sub_dst", res_dst, 4);
        tick();
        chk("b2b_fwd_valid", res_valid, 1);
        chk("b2b_fwd_data", res_data, 4);
        chk("b2b_fwd_dst", res_dst, 5);
        tick();

        // divide by zero, then a normal divide by immediate
        set_req(OC_DIV, 6, 1, 0, 1'b0, '0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("div0_data", res_data, 16'hFFFF);
        chk("div0_flag", res_div0, 1);
        chk("div0_dst", res_dst, 6);
        tick();
        read_reg(6, v);
        chk("div0_r6", v, 16'hFFFF);
        load(2, 16'd10);
        set_req(OC_DIV, 7, 2, 0, 1'b1, 16'd3);
        tick();
        in_valid = 1'b0;
        tick();
        chk("div_data", res_data, 3);
        chk("div_flag", res_div0, 0);
        tick();

        // external write is not forwarded to a same-cycle read
        set_req(OC_ADD, 7, 2, 0, 1'b1, 16'd0);
        wr_en = 1'b1; wr_idx = 3'd2; wr_data = 16'h0055;
        tick();
        in_valid = 1'b0; wr_en = 1'b0;
        tick();
        chk("wr_nofwd_data", res_data, 10);
        tick();
        read_reg(2, v);
        chk("wr_r2_loaded", v, 16'h0055);

        // backpressure: three offered, two accepted, then in-order drain
        res_ready = 1'b0;
        set_req(OC_ADD, 3, 1, 0, 1'b1, 16'd1);
        #1 chk("bp_rdy_a", in_ready, 1);
        tick();
        set_req(OC_ADD, 4, 1, 0, 1'b1, 16'd2);
        #1 chk("bp_rdy_b", in_ready, 1);
        chk("bp_vld_b", res_valid, 0);
        tick();
        set_req(OC_ADD, 5, 1, 0, 1'b1, 16'd3);
        #1 chk("bp_rdy_c", in_ready, 0);
        chk("bp_vld_c", res_valid, 1);
        chk("bp_data_c", res_data, 6);
        tick();
        chk("bp_hold_rdy", in_ready, 0);
        chk("bp_hold_data", res_data, 6);
        chk("bp_hold_dst", res_dst, 3);
        tick();
        chk("bp_hold2_data", res_data, 6);
        res_ready = 1'b1;
        #1 chk("bp_release_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_order_b", res_data, 7);
        tick();
        chk("bp_order_c", res_data, 8);
        chk("bp_order_c_dst", res_dst, 5);
        tick();
        chk("bp_drained", res_valid, 0);

        // writeback beats external write; mul truncation
        load(1, 16'h0100);
        set_req(OC_MUL, 3, 1, 1, 1'b0, '0);
        tick();
        in_valid = 1'b0;
        wr_en = 1'b1; wr_idx = 3'd3; wr_data = 16'hABCD;
        tick();
        wr_en = 1'b0;
        chk("mul_trunc", res_data, 0);
        chk("mul_dst", res_dst, 3);
        tick();
        read_reg(3, v);
        chk("wb_wins_r3", v, 0);

        // reset with IS and RS both occupied
        res_ready = 1'b0;
        set_req(OC_ADD, 5, 1, 0, 1'b1, 16'd1);
        tick();
        set_req(OC_ADD, 6, 1, 0, 1'b1, 16'd2);
        tick();
        in_valid = 1'b0;
        chk("mid_full_rdy", in_ready, 0);
        rst = 1'b1;
        wr_en = 1'b1; wr_idx = 3'd1; wr_data = 16'h7777;
        tick();
        rst = 1'b0; wr_en = 1'b0; res_ready = 1'b1;
        #1;
        chk("mid_rst_vld", res_valid, 0);
        chk("mid_rst_rdy", in_ready, 1);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_oc_a_b", {oc, a, b}, 0);
        for (int i = 0; i < RC; i++) begin
            read_reg(i, v);
            chk($sformatf("mid_rst_r%0d", i), v, 0);
        end

        // randomized run; dst 4..7 for requests, wr_idx 0..3 for loads
        for (int i = 0; i < RC; i++) mregs[i] = '0;
        cyc = 0;
        for (int it = 0; it < 600; it++) begin
            if (it >= 592) begin
                in_valid = 1'b0; wr_en = 1'b0; res_ready = 1'b1;
            end else begin
                in_valid  = ($urandom_range(0, 3) != 0);
                wr_en     = ($urandom_range(0, 2) == 0);
                res_ready = ($urandom_range(0, 3) != 0);
            end
            in_oc     = 3'($urandom_range(0, 7));
            in_dst    = IW'($urandom_range(4, 7));
            in_src1   = IW'($urandom_range(0, 7));
            in_src2   = IW'($urandom_range(0, 7));
            in_imm_en = 1'($urandom_range(0, 1));
            in_imm    = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            wr_idx    = IW'($urandom_range(0, 3));
            wr_data   = DW'($urandom);
            #1;
            exp_rdy = (q.size() < 2) || res_ready;
            exp_vld = (q.size() > 0) && (q[0].acc < cyc);
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_res_valid", res_valid, exp_vld);
            if (exp_vld) begin
                chk("rnd_res_data", res_data, q[0].data);
                chk("rnd_res_dst", res_dst, q[0].dst);
                chk("rnd_res_div0", res_div0, q[0].div0);
            end
            acc = in_valid && exp_rdy;
            pop = exp_vld && res_ready;
            opa = mregs[in_src1];
            opb = in_imm_en ? in_imm : mregs[in_src2];
            r = ref_op(in_oc, opa, opb);
            @(posedge clk);
            cyc++;
            if (pop) void'(q.pop_front());
            if (acc) begin
                it_new.data = r[DW-1:0];
                it_new.dst  = in_dst;
                it_new.div0 = r[DW];
                it_new.acc  = cyc;
                q.push_back(it_new);
                mregs[in_dst] = r[DW-1:0];
            end
            if (wr_en) mregs[wr_idx] = wr_data;
            #1;
        end
        chk("rnd_drained", q.size(), 0);
        idle();
        for (int i = 0; i < RC; i++) begin
            read_reg(i, v);
            chk($sformatf("rnd_final_r%0d", i), v, mregs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
